// File: rtl/monitor_pkg.sv
// Shared definitions for the multi-channel sample monitor: view-mode
// encodings and the min/max comparison helper.
package monitor_pkg;

  typedef enum logic [1:0] {
    MODE_LIVE = 2'd0,
    MODE_MIN  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_SPAN = 2'd3
  } mode_e;

  // Less-than on values zero-extended to 64 bits. For a signed compare the
  // caller passes the sample's sign-bit position in msb; flipping that bit
  // on both operands maps two's-complement order onto unsigned order.
  // Samples wider than 64 bits are not supported by this helper.
  function automatic logic less_than(input logic [63:0] a,
                                     input logic [63:0] b,
                                     input logic [63:0] msb,
                                     input bit          is_signed);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = is_signed ? (a ^ msb) : a;
    bx = is_signed ? (b ^ msb) : b;
    return ax < bx;
  endfunction

endpackage

// File: rtl/multi_channel_monitor_if.sv
// Bus between the debug host (or bench) and the monitor.
//
// Handshake: there is no ready and no backpressure. in_valid is a strobe
// meaning every channel of data_in holds a sample on that clock edge; the
// monitor always accepts it unless freeze or clear is high. sel/mode are
// plain levels; probe_out, count_out, sat and empty are registered and
// reflect sel/mode and the statistics one clock after they change.
interface multi_channel_monitor_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int COUNT_W  = 24,
  parameter int SEL_W    = 2
);
  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]          sel;
  logic [1:0]                mode;
  logic                      freeze;
  logic                      clear;
  logic [WIDTH-1:0]          probe_out;
  logic [COUNT_W-1:0]        count_out;
  logic                      sat;
  logic                      empty;

  modport master (
    output in_valid, data_in, sel, mode, freeze, clear,
    input  probe_out, count_out, sat, empty
  );

  modport slave (
    input  in_valid, data_in, sel, mode, freeze, clear,
    output probe_out, count_out, sat, empty
  );
endinterface

// File: rtl/monitor_channel.sv
// Statistics for one sample stream: last value, running min/max, a
// saturating sample counter with sticky saturation flag, and an empty flag.
module monitor_channel
  import monitor_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SIGNED  = 1,
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               take,     // sample accepted this edge
  input  logic               clear,
  input  logic [WIDTH-1:0]   sample,
  output logic [WIDTH-1:0]   last,
  output logic [WIDTH-1:0]   min_v,
  output logic [WIDTH-1:0]   max_v,
  output logic [COUNT_W-1:0] count,
  output logic               sat,
  output logic               empty
);

  localparam logic [63:0] MSB = 64'(1) << (WIDTH - 1);

  logic [COUNT_W-1:0] count_inc;
  logic               lt_min;
  logic               gt_max;

  assign count_inc = count + COUNT_W'(1);
  assign lt_min    = less_than(64'(sample), 64'(min_v), MSB, SIGNED != 0);
  assign gt_max    = less_than(64'(max_v), 64'(sample), MSB, SIGNED != 0);

  // Statistic registers; clear beats a sample arriving on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= '0;
      min_v <= '0;
      max_v <= '0;
      count <= '0;
      sat   <= 1'b0;
      empty <= 1'b1;
    end else if (clear) begin
      last  <= '0;
      min_v <= '0;
      max_v <= '0;
      count <= '0;
      sat   <= 1'b0;
      empty <= 1'b1;
    end else if (take) begin
      last <= sample;
      if (empty) begin
        min_v <= sample;
        max_v <= sample;
        empty <= 1'b0;
      end else begin
        if (lt_min) min_v <= sample;
        if (gt_max) max_v <= sample;
      end
      if (count != '1) begin
        count <= count_inc;
        if (count_inc == '1) sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_channel_monitor.sv
// Multi-channel debug monitor: per-channel statistics plus a registered
// probe view of one selected channel (live / min / max / span).
module multi_channel_monitor
  import monitor_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int SIGNED   = 1,
  parameter int COUNT_W  = 24,
  parameter int SEL_W    = 2
) (
  input logic clk,
  input logic rst,
  multi_channel_monitor_if.slave bus
);

  logic [WIDTH-1:0]   ch_last  [CHANNELS];
  logic [WIDTH-1:0]   ch_min   [CHANNELS];
  logic [WIDTH-1:0]   ch_max   [CHANNELS];
  logic [COUNT_W-1:0] ch_count [CHANNELS];
  logic               ch_sat   [CHANNELS];
  logic               ch_empty [CHANNELS];

  logic take;
  assign take = bus.in_valid && !bus.freeze;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    monitor_channel #(
      .WIDTH   (WIDTH),
      .SIGNED  (SIGNED),
      .COUNT_W (COUNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .take   (take),
      .clear  (bus.clear),
      .sample (bus.data_in[k*WIDTH +: WIDTH]),
      .last   (ch_last[k]),
      .min_v  (ch_min[k]),
      .max_v  (ch_max[k]),
      .count  (ch_count[k]),
      .sat    (ch_sat[k]),
      .empty  (ch_empty[k])
    );
  end

  logic [WIDTH-1:0]   sel_last;
  logic [WIDTH-1:0]   sel_min;
  logic [WIDTH-1:0]   sel_max;
  logic [COUNT_W-1:0] sel_count;
  logic               sel_sat;
  logic               sel_empty;

  // Channel select; an out-of-range sel leaves the idle/empty defaults.
  always_comb begin
    sel_last  = '0;
    sel_min   = '0;
    sel_max   = '0;
    sel_count = '0;
    sel_sat   = 1'b0;
    sel_empty = 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_last  = ch_last[k];
        sel_min   = ch_min[k];
        sel_max   = ch_max[k];
        sel_count = ch_count[k];
        sel_sat   = ch_sat[k];
        sel_empty = ch_empty[k];
      end
    end
  end

  logic [WIDTH:0]   span_x;
  logic [WIDTH-1:0] span_v;
  logic [WIDTH-1:0] probe_d;

  // Span in WIDTH+1 bits so a signed max-min never wraps, clamped to WIDTH.
  always_comb begin
    if (SIGNED != 0) span_x = {sel_max[WIDTH-1], sel_max} - {sel_min[WIDTH-1], sel_min};
    else             span_x = {1'b0, sel_max} - {1'b0, sel_min};
    span_v = span_x[WIDTH] ? '1 : span_x[WIDTH-1:0];
  end

  // View-mode mux feeding the probe register.
  always_comb begin
    probe_d = '0;
    case (bus.mode)
      MODE_LIVE: probe_d = sel_last;
      MODE_MIN:  probe_d = sel_min;
      MODE_MAX:  probe_d = sel_max;
      MODE_SPAN: probe_d = sel_empty ? '0 : span_v;
      default:   probe_d = '0;
    endcase
  end

  logic [WIDTH-1:0]   probe_q;
  logic [COUNT_W-1:0] count_q;
  logic               sat_q;
  logic               empty_q;

  // Output register: one clock from sel/mode/statistic change to the probe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_q <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      probe_q <= probe_d;
      count_q <= sel_count;
      sat_q   <= sel_sat;
      empty_q <= sel_empty;
    end
  end

  assign bus.probe_out = probe_q;
  assign bus.count_out = count_q;
  assign bus.sat       = sat_q;
  assign bus.empty     = empty_q;

endmodule

// File: doc/multi_channel_monitor.md
Name: multi_channel_monitor

Overview:
- Parametrised successor to the single-wire debug probe.
- Watches CHANNELS sample streams of WIDTH bits with a shared valid strobe.
- Per channel, tracks last, minimum and maximum values and a sample count.
- A debug host selects one channel and a view mode; the result appears on registered probe outputs that feed the JTAG source/probe fabric or a bench. On non-Altera builds the outputs are used directly.

Parameters:
- CHANNELS, 4, number of monitored streams (1..16)
- WIDTH, 16, bits per sample
- SIGNED, 1, 1 = two's-complement min/max compare, 0 = unsigned
- COUNT_W, 24, width of the per-channel sample counter
- SEL_W, 2, channel select width; must satisfy 2**SEL_W >= CHANNELS

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  all channels carry a valid sample this cycle
- data_in  in  CHANNELS*WIDTH  packed samples; channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  channel to display
- mode  in  2  0 = LIVE, 1 = MIN, 2 = MAX, 3 = SPAN (max-min)
- freeze  in  1  level; while high, statistics stop updating
- clear  in  1  one-cycle pulse; resets all statistics
- probe_out  out  WIDTH  selected statistic, registered
- count_out  out  COUNT_W  sample count of the selected channel, registered
- sat  out  1  selected channel's counter has saturated
- empty  out  1  selected channel has seen no sample since reset or clear

Behaviour:
- Reset (async, rst=1):
  - last, min, max = 0; count = 0; per-channel empty flag = 1.
  - probe_out = 0, count_out = 0, sat = 0, empty = 1.
- Per-channel update happens on a clk edge with in_valid=1, freeze=0 and clear=0:
  - last <= sample.
  - If the channel is empty: min <= sample, max <= sample, empty flag <= 0.
  - Otherwise: min <= sample if sample < min; max <= sample if sample > max. Compare is signed if SIGNED=1, else unsigned.
  - count <= count+1, saturating at all-ones. Saturation sets a sticky sat flag, cleared only by clear or reset.
- clear=1 returns every channel to its reset state on that edge and takes priority over in_valid. A sample arriving in the same cycle as clear is discarded.
- freeze=1 drops samples entirely: they are not captured and count does not advance. clear still acts while freeze is high.
- Output stage (registered, 1 clk latency from sel/mode/statistic change):
  - LIVE: probe_out = last.
  - MIN: probe_out = min.
  - MAX: probe_out = max.
  - SPAN: probe_out = max - min computed in WIDTH+1 bits, then saturated to WIDTH bits unsigned. Output is 0 when empty.
  - count_out, sat and empty track the selected channel under the same 1-cycle latency.
- Statistics update and the output register share one edge. probe_out therefore shows the new statistic 2 cycles after the sample edge: sample → stat register → output register.
- sel >= CHANNELS: probe_out = 0, count_out = 0, sat = 0, empty = 1.
- Reset asserted mid-stream clears everything immediately; no partial state survives deassertion.
- Equal compare (sample == min or max) leaves the register unchanged.

Decomposition:
- Package monitor_pkg:
  - mode encodings MODE_LIVE/MIN/MAX/SPAN.
  - helper function for the signed/unsigned less-than compare.
- Sub-module monitor_channel: one channel's last/min/max/count/sat/empty registers, instantiated CHANNELS times via generate.
- The top level holds the selection mux, SPAN arithmetic and the output register.

Test Plan:
- Reset release, CHANNELS=4 → all outputs 0, empty=1. Ch0 samples 5, -3, 7 (SIGNED=1), sel=0 → after the last sample: MIN shows 0xFFFD, MAX shows 7, LIVE shows 7, count 3, empty=0.
- Same samples with SIGNED=0 → MIN shows 5, MAX shows 0xFFFD. SPAN shows 0xFFF8.
- freeze=1 across 4 valid samples → count unchanged and min/max unchanged. Then clear pulse with in_valid=1 → all statistics zeroed, empty=1, and that sample is not counted.
- COUNT_W=4, 20 valid samples → count_out holds at 15 and sat=1. Clear → count 0, sat 0.
- Switch sel 0→2 with distinct data per channel → probe_out reflects ch2 exactly 1 cycle later. sel=3 with CHANNELS=3 → all outputs 0, empty=1.
- Assert rst asynchronously between edges mid-stream → outputs go to reset values immediately. The first sample after release reinitialises min=max=sample.
